// File: rtl/opfetch_pkg.sv
// Shared widths, types and helpers for the operand fetch stage and its scoreboard.
// Widths here must match the 8x16 register file this stage reads from.
package opfetch_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int NREG   = 2 ** REG_AW;
  localparam int CTRL_W = 8;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    word_t             op0;
    word_t             op1;
    reg_addr_t         rd;
    logic              rd_we;
    logic [CTRL_W-1:0] ctrl;
  } opfetch_bundle_t;

  // True when the writeback snoop is writing register ra this cycle.
  function automatic logic wb_hits(input logic en, input reg_addr_t wa, input reg_addr_t ra);
    return en && (wa == ra);
  endfunction

endpackage

// File: rtl/opfetch_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue of a
// writing instruction, cleared on writeback; a same-cycle set beats the clear.
module opfetch_scoreboard
  import opfetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_set_en,
  input  logic [REG_AW-1:0] i_set_addr,
  input  logic              i_clr_en,
  input  logic [REG_AW-1:0] i_clr_addr,
  input  logic [REG_AW-1:0] i_q0_addr,
  input  logic [REG_AW-1:0] i_q1_addr,
  input  logic [REG_AW-1:0] i_qd_addr,
  output logic              o_busy0,
  output logic              o_busy1,
  output logic              o_busyd
);

  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_next;

  // Clear first, then set, so an issue to the register being written back stays pending.
  always_comb begin
    // NOTE: assigning the whole vector before any conditional update keeps this purely combinational (no latch).
    w_pend_next = r_pend;
    if (i_clr_en) w_pend_next[i_clr_addr] = 1'b0;
    if (i_set_en) w_pend_next[i_set_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) r_pend <= '0;
    else     r_pend <= w_pend_next;
  end

  assign o_busy0 = r_pend[i_q0_addr];
  assign o_busy1 = r_pend[i_q1_addr];
  assign o_busyd = r_pend[i_qd_addr];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads two regfile ports, resolves RAW/WAW hazards via the scoreboard,
// and registers one operand bundle for execute. `OPFETCH_BYPASS_EN enables writeback forwarding.
module operand_fetch
  import opfetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs0,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [REG_AW-1:0] rf_rd0_addr,
  output logic [REG_AW-1:0] rf_rd1_addr,
  input  logic [DATA_W-1:0] rf_rd0_data,
  input  logic [DATA_W-1:0] rf_rd1_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op0,
  output logic [DATA_W-1:0] out_op1,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_rd_we,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic            w_busy0, w_busy1, w_busyd;
  logic            w_haz0, w_haz1, w_hazd;
  logic            w_stall, w_accept;
  word_t           w_op0, w_op1;
  opfetch_bundle_t w_bundle_next;
  opfetch_bundle_t r_bundle;
  logic            r_out_valid;

  assign rf_rd0_addr = in_rs0;
  assign rf_rd1_addr = in_rs1;

  opfetch_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (w_accept && in_rd_we),
    .i_set_addr (in_rd),
    .i_clr_en   (wb_en),
    .i_clr_addr (wb_addr),
    .i_q0_addr  (in_rs0),
    .i_q1_addr  (in_rs1),
    .i_qd_addr  (in_rd),
    .o_busy0    (w_busy0),
    .o_busy1    (w_busy1),
    .o_busyd    (w_busyd)
  );

`ifdef OPFETCH_BYPASS_EN
  logic w_hit0, w_hit1, w_hitd;

  assign w_hit0 = wb_hits(wb_en, wb_addr, in_rs0);
  assign w_hit1 = wb_hits(wb_en, wb_addr, in_rs1);
  assign w_hitd = wb_hits(wb_en, wb_addr, in_rd);

  // A writeback landing this cycle satisfies the dependency, so it is not a hazard.
  assign w_haz0 = w_busy0 && !w_hit0;
  assign w_haz1 = w_busy1 && !w_hit1;
  assign w_hazd = in_rd_we && w_busyd && !w_hitd;

  assign w_op0 = w_hit0 ? wb_data : rf_rd0_data;
  assign w_op1 = w_hit1 ? wb_data : rf_rd1_data;
`else
  logic w_unused_wb_data;

  // Without forwarding the instruction waits until the regfile holds the new value.
  assign w_haz0 = w_busy0;
  assign w_haz1 = w_busy1;
  assign w_hazd = in_rd_we && w_busyd;

  assign w_op0 = rf_rd0_data;
  assign w_op1 = rf_rd1_data;

  assign w_unused_wb_data = ^wb_data;
`endif

  assign w_stall  = w_haz0 || w_haz1 || w_hazd;
  assign in_ready = !w_stall && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_bundle_next       = '0;
    w_bundle_next.op0   = w_op0;
    w_bundle_next.op1   = w_op1;
    w_bundle_next.rd    = in_rd;
    w_bundle_next.rd_we = in_rd_we;
    w_bundle_next.ctrl  = in_ctrl;
  end

  // The bundle only loads on accept, so it holds while execute back-pressures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_bundle    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_bundle    <= w_bundle_next;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_op0   = r_bundle.op0;
  assign out_op1   = r_bundle.op1;
  assign out_rd    = r_bundle.rd;
  assign out_rd_we = r_bundle.rd_we;
  assign out_ctrl  = r_bundle.ctrl;

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Read-side initiator for the 8x16 register file.
- Takes decoded instructions from decode with a valid/ready handshake and drives the two regfile read addresses.
- Returns the two operands to execute through one registered output stage.
- Tracks in-flight destination writes in a scoreboard; forwards writeback data or stalls to resolve RAW and WAW hazards.

Parameters:
- DATA_W, 16, operand/register width; must match regfile data width.
- REG_AW, 3, register address width; NREG = 2**REG_AW = 8.
- CTRL_W, 8, opaque control bits passed from decode to execute unchanged.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  decode holds a valid instruction.
- in_ready  out  1  block accepts the instruction this cycle.
- in_rs0  in  REG_AW  source register 0.
- in_rs1  in  REG_AW  source register 1.
- in_rd  in  REG_AW  destination register.
- in_rd_we  in  1  instruction writes in_rd.
- in_ctrl  in  CTRL_W  passthrough control.
- rf_rd0_addr  out  REG_AW  to regfile rd0_addr.
- rf_rd1_addr  out  REG_AW  to regfile rd1_addr.
- rf_rd0_data  in  DATA_W  from regfile rd0_data (combinational read).
- rf_rd1_data  in  DATA_W  from regfile rd1_data.
- wb_en  in  1  snoop of regfile wr_en.
- wb_addr  in  REG_AW  snoop of regfile wr_addr.
- wb_data  in  DATA_W  snoop of regfile wr_data.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_op0, out_op1  out  DATA_W  operands.
- out_rd  out  REG_AW  destination passthrough.
- out_rd_we  out  1  write-enable passthrough.
- out_ctrl  out  CTRL_W  control passthrough.

Behaviour:
- Read addresses: rf_rd0_addr = in_rs0 and rf_rd1_addr = in_rs1, combinational, every cycle.
- Scoreboard: NREG pending bits `pend`. Reset clears all bits to 0.
  - On an accepted write instruction (accept && in_rd_we), set pend[in_rd].
  - On wb_en, clear pend[wb_addr].
  - If set and clear hit the same index in the same cycle, set wins and the bit ends at 1.
- Hazard on a source rsX (X = 0, 1): hazard when pend[rsX] = 1 and NOT (wb_en && wb_addr == rsX).
- WAW hazard: in_rd_we && pend[in_rd] = 1 && NOT (wb_en && wb_addr == in_rd).
- Stall is the OR of the rs0 hazard, the rs1 hazard and the WAW hazard.
- Handshake:
  - in_ready = ~stall && (~out_valid || out_ready).
  - accept = in_valid && in_ready.
  - in_ready may depend combinationally on in_* signals and on out_ready.
- Operand selection: opX = wb_data if wb_en && wb_addr == rsX; otherwise rf_rdX_data. Both sources equal to the same register resolve identically.
- Output stage (latency 1 cycle from accept to out_valid):
  - On accept, register the operands, in_rd, in_rd_we and in_ctrl, and set out_valid = 1.
  - Else if out_ready, set out_valid = 0.
  - Outputs hold stable while out_valid && ~out_ready. No combinational path from in_* to out_*.
- Throughput: 1 instruction per cycle with no hazards and out_ready held high.
- Reset values: out_valid = 0, out_op0 = out_op1 = 0, out_rd = 0, out_rd_we = 0, out_ctrl = 0, pend = 0.
- Reset mid-operation: the in-flight bundle is dropped and all pending bits are lost. The surrounding pipeline is reset together with this block.
- wb_en for a register whose pend bit is 0 is legal: it is forwarded and clears nothing.

Optional Feature:
- Macro OPFETCH_BYPASS_EN.
- Defined: behaviour exactly as above (forwarding; same-cycle writeback resolves the hazard).
- Undefined:
  - No forwarding; opX = rf_rdX_data always.
  - The hazard is simply pend[rsX] (WAW: pend[in_rd]), so the instruction stalls through the writeback cycle.
  - The instruction is accepted on the next cycle, when the regfile holds the new value.

Decomposition:
- Package opfetch_pkg holds:
  - DATA_W and REG_AW constants;
  - typedefs word_t (logic [DATA_W-1:0]) and reg_addr_t (logic [REG_AW-1:0]);
  - an opfetch_bundle_t struct {op0, op1, rd, rd_we, ctrl}.
- Sub-module opfetch_scoreboard:
  - holds the pend vector and its set/clear priority;
  - exposes a combinational busy query per source and for rd.

Test Plan:
- Reset, then issue rs0=1, rs1=2 (regfile r1=16'h0011, r2=16'h0022, out_ready=1) -> next cycle out_valid=1, out_op0=16'h0011, out_op1=16'h0022.
- Issue A (rd=3, rd_we=1), then B (rs0=3) -> in_ready=0 for B until wb_en with wb_addr=3, wb_data=16'hBEEF.
  - With OPFETCH_BYPASS_EN: B is accepted in that same cycle with out_op0=16'hBEEF.
  - Without it: B is accepted one cycle later.
- Hold out_ready=0 with a bundle held in the output stage -> in_ready=0 and out_* stable for 5 cycles. Raise out_ready -> a new bundle is accepted the same cycle.
- WAW: A (rd=5) pending, B (rd=5, rd_we=1) stalls; at wb_en to r5, B is accepted and pend[5] stays 1.
- Back-to-back hazard-free stream of 8 instructions -> 8 out bundles on 8 consecutive cycles, in order, with ctrl values matching.
- Assert rst while pend[3]=1 and out_valid=1 -> out_valid=0 and pend=0 immediately; an instruction reading r3 after reset is accepted without a stall.
